// File: rtl/ysyx_22050243_dmem_ctrl.sv
// ysyx_22050243_dmem_ctrl: single-outstanding data memory with fixed latency.
// Optional address bound check: define YSYX_22050243_DMEM_BOUND_CHK_EN.
module ysyx_22050243_dmem_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int DEPTH      = 4096,
    parameter int LATENCY    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = $clog2(DEPTH);
    localparam int WW  = ADDR_WIDTH - OFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic                    init_q;
    logic                    wen_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NB-1:0]           wmask_q;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    accept;
    logic                    enter_resp;
    logic                    c_wen;
    logic [ADDR_WIDTH-1:0]   c_addr;
    logic [DATA_WIDTH-1:0]   c_wdata;
    logic [NB-1:0]           c_wmask;
    logic [WW-1:0]           word;
    logic [WW-1:0]           word_hi;
    logic [IW-1:0]           idx;
    logic                    oob;
    logic                    mem_we;
    logic                    unused_bits;

    assign accept = req_valid && req_ready;

    // With LATENCY=1 the commit edge is the accept edge, so use live inputs
    assign c_wen   = (state_q == S_IDLE) ? req_wen   : wen_q;
    assign c_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign c_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign c_wmask = (state_q == S_IDLE) ? req_wmask : wmask_q;

    assign word    = c_addr[ADDR_WIDTH-1:OFF];
    assign word_hi = word >> IW;
    assign idx     = word[IW-1:0];

`ifdef YSYX_22050243_DMEM_BOUND_CHK_EN
    assign oob = |word_hi;
`else
    assign oob = 1'b0;
`endif

    assign unused_bits = ^{c_addr[OFF-1:0], word_hi};

    assign enter_resp = ((state_q == S_IDLE) && accept && (LATENCY == 1))
                     || ((state_q == S_WAIT) && (cnt_q == 3'd1));

    assign mem_we = enter_resp && c_wen && !oob;

    // State register, latency counter and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            init_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            init_q  <= 1'b1;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Capture the request fields on accept; later input changes are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (accept) begin
            wen_q   <= req_wen;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
        end
    end

    // Storage is never reset; byte lanes written only on the commit edge
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (c_wmask[i]) begin
                    mem[idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

    // Next-state, counter and response data selection
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 3'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
        if (enter_resp) begin
            rdata_d = (c_wen || oob) ? '0 : mem[idx];
            err_d   = oob;
        end
    end

    // Outputs decoded from state; response fields forced to 0 when idle
    always_comb begin
        req_ready  = init_q && (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_rdata = resp_valid ? rdata_q : '0;
        resp_err   = resp_valid ? err_q : 1'b0;
    end

endmodule
